// File: rtl/text_pkg.sv
// text_pkg -- definitions shared by the run-length expander and the upstream
// run counter.
//   CHAR_FIRST/CHAR_LAST : legal run characters ('a'..'d')
//   COUNT_W              : run-length field width (0 encodes 8)
//   REM_W                : width of the beats-remaining counter (1..8)
//   PAIR_W               : width of one {char, count} FIFO entry
//   exp_state_t          : expander FSM encoding
package text_pkg;

  localparam logic [7:0] CHAR_FIRST = 8'd97;
  localparam logic [7:0] CHAR_LAST  = 8'd100;
  localparam int         COUNT_W    = 3;
  localparam int         REM_W      = 4;
  localparam int         PAIR_W     = 8 + COUNT_W;
  localparam int         LEVEL_W    = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } exp_state_t;

  function automatic logic is_run_char(input logic [7:0] c);
    return (c >= CHAR_FIRST) && (c <= CHAR_LAST);
  endfunction

  // A zero count stands for a full run of eight characters.
  function automatic logic [REM_W-1:0] count_to_rem(input logic [COUNT_W-1:0] c);
    return (c == '0) ? 4'd8 : {1'b0, c};
  endfunction

endpackage

// File: rtl/text_expand_if.sv
// text_expand_if -- run-pair input and character-stream output of the expander.
//   IN_DATA/IN_COUNT/IN_VALID : finished run from upstream (no backpressure)
//   OUT/OUT_VALID/OUT_READY   : expanded character stream, valid/ready
//   LEVEL/OVF/ERR             : FIFO occupancy and sticky status flags
// modport slave  : the expander side
// modport master : the producer/consumer side
interface text_expand_if;
  import text_pkg::*;

  logic [7:0]         IN_DATA;
  logic [COUNT_W-1:0] IN_COUNT;
  logic               IN_VALID;
  logic [7:0]         OUT;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [LEVEL_W-1:0] LEVEL;
  logic               OVF;
  logic               ERR;

  modport slave (
    input  IN_DATA, IN_COUNT, IN_VALID, OUT_READY,
    output OUT, OUT_VALID, LEVEL, OVF, ERR
  );

  modport master (
    output IN_DATA, IN_COUNT, IN_VALID, OUT_READY,
    input  OUT, OUT_VALID, LEVEL, OVF, ERR
  );

endinterface

// File: rtl/text_fifo.sv
// text_fifo -- small synchronous FIFO holding run pairs.
//   CLK, RST  : clock, asynchronous active-low reset (pointers only)
//   push/wr_data : write request and data; ignored when full unless popping
//   pop/rd_data  : read request; rd_data always shows the current head
//   full/empty/level : occupancy status
// The head is read combinationally so the consumer can pop and load it on
// the same edge.
module text_fifo
  import text_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PAIR_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               push,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   rd_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  // Storage carries no reset: validity is defined by the pointers alone.
  logic [WIDTH-1:0] mem [DEPTH];

  // One extra MSB on each pointer separates full (MSBs differ) from empty.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] diff;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign diff    = wr_ptr_reg - rd_ptr_reg;
  assign level   = LEVEL_W'(diff);
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/text_expand.sv
// text_expand -- expands {char, count} run pairs into a character stream.
//   CLK  : clock, all state changes on the rising edge
//   RST  : asynchronous active-low reset
//   bus  : text_expand_if.slave (run input, stream output, LEVEL/OVF/ERR)
// Pairs are queued in text_fifo; an IDLE/EMIT FSM pops the head, holds the
// character on OUT and counts the remaining beats, chaining directly into the
// next pair with no bubble.
module text_expand
  import text_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  text_expand_if.slave  bus
);

  exp_state_t       state_reg;
  logic [REM_W-1:0] rem_reg;
  logic [7:0]       out_reg;
  logic             ovf_reg;
  logic             err_reg;

  logic [PAIR_W-1:0]  head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;
  logic               in_legal;
  logic               last_beat;
  logic               pop;
  logic               push;

  assign in_legal  = is_run_char(bus.IN_DATA);
  assign last_beat = (state_reg == ST_EMIT) && bus.OUT_READY && (rem_reg == 4'd1);
  assign pop       = !fifo_empty && ((state_reg == ST_IDLE) || last_beat);
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign push      = bus.IN_VALID && in_legal && (!fifo_full || pop);

  text_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAIR_W)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (push),
    .wr_data ({bus.IN_DATA, bus.IN_COUNT}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      rem_reg   <= '0;
      out_reg   <= '0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      if (bus.IN_VALID && !in_legal) begin
        err_reg <= 1'b1;
      end
      if (bus.IN_VALID && in_legal && fifo_full && !pop) begin
        ovf_reg <= 1'b1;
      end

      if (pop) begin
        // Load from IDLE, or reload on the last beat of the current run.
        state_reg <= ST_EMIT;
        out_reg   <= head[PAIR_W-1:COUNT_W];
        rem_reg   <= count_to_rem(head[COUNT_W-1:0]);
      end else if (last_beat) begin
        state_reg <= ST_IDLE;
        rem_reg   <= '0;
      end else if ((state_reg == ST_EMIT) && bus.OUT_READY) begin
        rem_reg <= rem_reg - 1'b1;
      end
    end
  end

  assign bus.OUT       = out_reg;
  assign bus.OUT_VALID = (state_reg == ST_EMIT);
  assign bus.LEVEL     = fifo_level;
  assign bus.OVF       = ovf_reg;
  assign bus.ERR       = err_reg;

endmodule

// File: tb/tb_text_expand.sv
// tb_text_expand -- directed, table-driven bench for text_expand (DEPTH=4).
// Each table row is one clock cycle: inputs for that cycle and the outputs
// expected to be visible during it. Reset behaviour is exercised by hand.
module tb_text_expand;

  logic CLK;
  logic RST;

  text_expand_if ifc ();

  text_expand #(
    .DEPTH (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic [2:0] ic;
    logic       rdy;
    logic       ev;
    logic [7:0] eo;
    logic [4:0] el;
    logic       eovf;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic iv, input logic [7:0] id, input logic [2:0] ic,
                     input logic rdy, input logic ev, input logic [7:0] eo,
                     input logic [4:0] el, input logic eovf, input logic eerr);
    vec_t v;
    v.iv = iv; v.id = id; v.ic = ic; v.rdy = rdy;
    v.ev = ev; v.eo = eo; v.el = el; v.eovf = eovf; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic [2:0] ic,
                       input logic rdy);
    ifc.IN_VALID  = iv;
    ifc.IN_DATA   = id;
    ifc.IN_COUNT  = ic;
    ifc.OUT_READY = rdy;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [7:0] eo,
                            input logic [4:0] el, input logic eovf, input logic eerr);
    check({tag, "_out_valid"}, 32'(ifc.OUT_VALID), 32'(ev));
    if (ev) check({tag, "_out"}, 32'(ifc.OUT), 32'(eo));
    check({tag, "_level"}, 32'(ifc.LEVEL), 32'(el));
    check({tag, "_ovf"},   32'(ifc.OVF),   32'(eovf));
    check({tag, "_err"},   32'(ifc.ERR),   32'(eerr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single 'a' x3: beats in cycles N+2..N+4, then idle.
    add(1, 97, 3, 1,  0,  0, 0, 0, 0);
    add(0,  0, 0, 1,  0,  0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, 97, 0, 0, 0);
    add(0,  0, 0, 1,  0,  0, 0, 0, 0);
    // ('b',2) then ('c',1) back to back: 98,98,99 without a bubble.
    add(1, 98, 2, 1,  0,  0, 0, 0, 0);
    add(1, 99, 1, 1,  0,  0, 1, 0, 0);
    add(0,  0, 0, 1,  1, 98, 1, 0, 0);
    add(0,  0, 0, 1,  1, 98, 1, 0, 0);
    add(0,  0, 0, 1,  1, 99, 0, 0, 0);
    add(0,  0, 0, 1,  0,  0, 0, 0, 0);
    // ('d',0) expands to exactly eight beats.
    add(1, 100, 0, 1, 0,  0, 0, 0, 0);
    add(0,  0, 0, 1,  0,  0, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 1, 100, 0, 0, 0);
    add(0,  0, 0, 1,  0,  0, 0, 0, 0);
    // Illegal character mid-stream: dropped, ERR set, stream untouched.
    add(1, 97, 2, 1,  0,  0, 0, 0, 0);
    add(1, 120, 3, 1, 0,  0, 1, 0, 0);
    add(0,  0, 0, 1,  1, 97, 0, 0, 1);
    add(0,  0, 0, 1,  1, 97, 0, 0, 1);
    add(0,  0, 0, 1,  0,  0, 0, 0, 1);
    // Six pairs with OUT_READY=0: first popped, four stored, sixth dropped.
    add(1, 97, 1, 0,  0,  0, 0, 0, 1);
    add(1, 98, 1, 0,  0,  0, 1, 0, 1);
    add(1, 99, 1, 0,  1, 97, 1, 0, 1);
    add(1, 100, 1, 0, 1, 97, 2, 0, 1);
    add(1, 97, 1, 0,  1, 97, 3, 0, 1);
    add(1, 98, 1, 0,  1, 97, 4, 0, 1);
    add(0,  0, 0, 0,  1, 97, 4, 1, 1);
    // Drain: stored order b,c,d,a; the dropped 'b' never appears.
    add(0,  0, 0, 1,  1, 97, 4, 1, 1);
    add(0,  0, 0, 1,  1, 98, 3, 1, 1);
    add(0,  0, 0, 1,  1, 99, 2, 1, 1);
    add(0,  0, 0, 1,  1, 100, 1, 1, 1);
    add(0,  0, 0, 1,  1, 97, 0, 1, 1);
    add(0,  0, 0, 1,  0,  0, 0, 1, 1);

    // Reset state.
    RST = 1'b0;
    drive(0, 0, 0, 1);
    repeat (2) @(negedge CLK);
    check("reset_out", 32'(ifc.OUT), 32'd0);
    check_outs("reset", 0, 0, 0, 0, 0);
    RST = 1'b1;

    foreach (vecs[i]) begin
      @(negedge CLK);
      check_outs($sformatf("v%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].el,
                 vecs[i].eovf, vecs[i].eerr);
      $display("vec %0d: in_v=%0d data=%0d cnt=%0d rdy=%0d | out_v=%0d out=%0d level=%0d ovf=%0d err=%0d",
               i, vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].rdy,
               ifc.OUT_VALID, ifc.OUT, ifc.LEVEL, ifc.OVF, ifc.ERR);
      drive(vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].rdy);
    end

    // Reset mid-run: ('a',7) emitting with REM=5 and ('b',2) queued.
    @(negedge CLK); drive(1, 97, 7, 1);
    @(negedge CLK); drive(1, 98, 2, 1);
    @(negedge CLK); drive(0, 0, 0, 1);
    check_outs("rst_seq_first", 1, 97, 1, 1, 1);
    @(negedge CLK);
    @(negedge CLK);
    check_outs("rst_seq_rem5", 1, 97, 1, 1, 1);
    RST = 1'b0;
    #1;
    check("rst_async_out", 32'(ifc.OUT), 32'd0);
    check_outs("rst_async", 0, 0, 0, 0, 0);
    $display("txn reset asserted mid-run: out_v=%0d level=%0d", ifc.OUT_VALID, ifc.LEVEL);
    @(negedge CLK);
    check_outs("rst_held", 0, 0, 0, 0, 0);
    RST = 1'b1;
    @(negedge CLK); drive(1, 99, 2, 1);
    check_outs("post_rst_n", 0, 0, 0, 0, 0);
    @(negedge CLK); drive(0, 0, 0, 1);
    check_outs("post_rst_n1", 0, 0, 1, 0, 0);
    @(negedge CLK);
    check_outs("post_rst_n2", 1, 99, 0, 0, 0);
    @(negedge CLK);
    check_outs("post_rst_n3", 1, 99, 0, 0, 0);
    @(negedge CLK);
    check_outs("post_rst_n4", 0, 0, 0, 0, 0);
    $display("txn post-reset pair ('c',2) expanded");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
